bsg_gateway_clk_div_bank: RTL and testbench

BSG_GATEWAY_CLK_DIV_BANK -- requirements
Module: bsg_gateway_clk_div_bank

---
 rtl/bsg_gateway_clk_div_bank.sv | 165 ++++++++++++++++
 tb/tb_bsg_gateway_clk_div_bank.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_gateway_clk_div_bank.sv
// Bank of phase-alignable clock dividers gated by a qualified PLL lock.
// Ratio changes on running channels wait for a period boundary.
module bsg_gateway_clk_div_bank #(
    parameter int channels_p           = 4,
    parameter int div_width_p          = 8,
    parameter int lock_stable_cycles_p = 64,
    localparam int ch_width_lp   = (channels_p > 1) ? $clog2(channels_p) : 1,
    localparam int lock_width_lp = $clog2(lock_stable_cycles_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   pll_locked_i,
    input  logic                   cfg_v_i,
    input  logic [ch_width_lp-1:0] cfg_ch_i,
    input  logic [div_width_p-1:0] cfg_div_i,
    input  logic                   cfg_en_i,
    output logic                   cfg_ready_o,
    input  logic                   sync_i,
    output logic [channels_p-1:0]  tick_o,
    output logic [channels_p-1:0]  div_clk_o,
    output logic                   locked_o
);

    localparam logic [lock_width_lp-1:0] lock_max_lp =
        lock_width_lp'(lock_stable_cycles_p);
    localparam logic [lock_width_lp-1:0] lock_last_lp =
        lock_width_lp'(lock_stable_cycles_p - 1);

    logic                     sync1_q, sync2_q;
    logic [lock_width_lp-1:0] lock_cnt_q, lock_cnt_d;
    logic                     locked_q, locked_d;

    logic [channels_p-1:0]  en_q, en_d;
    logic [channels_p-1:0]  pv_q, pv_d;
    logic [channels_p-1:0]  pen_q, pen_d;
    logic [channels_p-1:0]  tick_q, tick_d;
    logic [channels_p-1:0]  dclk_q, dclk_d;
    logic [div_width_p-1:0] div_q  [channels_p];
    logic [div_width_p-1:0] div_d  [channels_p];
    logic [div_width_p-1:0] cnt_q  [channels_p];
    logic [div_width_p-1:0] cnt_d  [channels_p];
    logic [div_width_p-1:0] pdiv_q [channels_p];
    logic [div_width_p-1:0] pdiv_d [channels_p];

    logic accept, sync_fire, flush;
    logic hit, imm, nx_en;
    logic [div_width_p-1:0] nx_div;

    always_comb begin
        cfg_ready_o = 1'b1;
        for (int c = 0; c < channels_p; c++) begin
            if (cfg_ch_i == ch_width_lp'(c) && pv_q[c]) begin
                cfg_ready_o = 1'b0;
            end
        end
    end

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!sync2_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != lock_max_lp) begin
            lock_cnt_d = lock_cnt_q + lock_width_lp'(1);
        end
        locked_d = sync2_q & (locked_q | (lock_cnt_q == lock_last_lp));
    end

    assign accept    = cfg_v_i & cfg_ready_o;
    assign sync_fire = locked_q & sync_i;
    // Lock loss and sync both collapse pending state and restart phase.
    assign flush     = ~locked_d | sync_fire;

    always_comb begin
        en_d   = en_q;
        pv_d   = pv_q;
        pen_d  = pen_q;
        tick_d = tick_q;
        dclk_d = dclk_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        pdiv_d = pdiv_q;
        hit    = 1'b0;
        imm    = 1'b0;
        nx_en  = 1'b0;
        nx_div = '0;
        for (int c = 0; c < channels_p; c++) begin
            hit    = accept & (cfg_ch_i == ch_width_lp'(c));
            imm    = ~locked_q | ~en_q[c] | sync_i;
            nx_en  = pv_q[c] ? pen_q[c] : en_q[c];
            nx_div = pv_q[c] ? pdiv_q[c] : div_q[c];
            if (flush) begin
                en_d[c]   = nx_en;
                div_d[c]  = nx_div;
                cnt_d[c]  = nx_div;
                pv_d[c]   = 1'b0;
                tick_d[c] = 1'b0;
                dclk_d[c] = 1'b0;
            end else if (locked_q && en_q[c]) begin
                if (cnt_q[c] == '0) begin
                    tick_d[c] = 1'b1;
                    en_d[c]   = nx_en;
                    div_d[c]  = nx_div;
                    cnt_d[c]  = nx_div;
                    pv_d[c]   = 1'b0;
                    dclk_d[c] = nx_en & ~dclk_q[c];
                end else begin
                    tick_d[c] = 1'b0;
                    cnt_d[c]  = cnt_q[c] - div_width_p'(1);
                end
            end else begin
                tick_d[c] = 1'b0;
                dclk_d[c] = 1'b0;
                cnt_d[c]  = div_q[c];
            end
            if (hit && imm) begin
                en_d[c]  = cfg_en_i;
                div_d[c] = cfg_div_i;
                cnt_d[c] = cfg_div_i;
            end else if (hit) begin
                pv_d[c]   = 1'b1;
                pen_d[c]  = cfg_en_i;
                pdiv_d[c] = cfg_div_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            en_q       <= '0;
            pv_q       <= '0;
            pen_q      <= '0;
            tick_q     <= '0;
            dclk_q     <= '0;
            for (int c = 0; c < channels_p; c++) begin
                div_q[c]  <= '0;
                cnt_q[c]  <= '0;
                pdiv_q[c] <= '0;
            end
        end else begin
            sync1_q    <= pll_locked_i;
            sync2_q    <= sync1_q;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            en_q       <= en_d;
            pv_q       <= pv_d;
            pen_q      <= pen_d;
            tick_q     <= tick_d;
            dclk_q     <= dclk_d;
            for (int c = 0; c < channels_p; c++) begin
                div_q[c]  <= div_d[c];
                cnt_q[c]  <= cnt_d[c];
                pdiv_q[c] <= pdiv_d[c];
            end
        end
    end

    assign tick_o    = tick_q;
    assign div_clk_o = dclk_q;
    assign locked_o  = locked_q;

endmodule

// File: tb/tb_bsg_gateway_clk_div_bank.sv
// Directed bench for the clock divider bank: lock, divide, swap, sync,
// boundaries, lock loss and reset.
module tb_bsg_gateway_clk_div_bank;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       pll_locked_i;
    logic       cfg_v_i;
    logic [1:0] cfg_ch_i;
    logic [7:0] cfg_div_i;
    logic       cfg_en_i;
    logic       cfg_ready_o;
    logic       sync_i;
    logic [3:0] tick_o;
    logic [3:0] div_clk_o;
    logic       locked_o;

    logic       cfg2_v, cfg2_en, ready2, locked2, sync2;
    logic [1:0] cfg2_ch;
    logic [7:0] cfg2_div;
    logic [2:0] tick2, dclk2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    bsg_gateway_clk_div_bank dut (
        .clk_i(clk_i), .reset_i(reset_i), .pll_locked_i(pll_locked_i),
        .cfg_v_i(cfg_v_i), .cfg_ch_i(cfg_ch_i), .cfg_div_i(cfg_div_i),
        .cfg_en_i(cfg_en_i), .cfg_ready_o(cfg_ready_o), .sync_i(sync_i),
        .tick_o(tick_o), .div_clk_o(div_clk_o), .locked_o(locked_o)
    );

    bsg_gateway_clk_div_bank #(.channels_p(3), .lock_stable_cycles_p(2)) dut3 (
        .clk_i(clk_i), .reset_i(reset_i), .pll_locked_i(pll_locked_i),
        .cfg_v_i(cfg2_v), .cfg_ch_i(cfg2_ch), .cfg_div_i(cfg2_div),
        .cfg_en_i(cfg2_en), .cfg_ready_o(ready2), .sync_i(sync2),
        .tick_o(tick2), .div_clk_o(dclk2), .locked_o(locked2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] d,
                       input logic en);
        cfg_ch_i  = ch;
        cfg_div_i = d;
        cfg_en_i  = en;
        cfg_v_i   = 1'b1;
        step(1);
        cfg_v_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1;
        pll_locked_i = 1'b0;
        cfg_v_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0; cfg_en_i = 1'b0;
        sync_i = 1'b0;
        cfg2_v = 1'b0; cfg2_ch = '0; cfg2_div = '0; cfg2_en = 1'b0;
        sync2 = 1'b0;
        step(2);
        check_eq("rst_locked", locked_o, 0);
        check_eq("rst_tick", tick_o, 0);
        check_eq("rst_dclk", div_clk_o, 0);
        check_eq("rst_ready", cfg_ready_o, 1);
        reset_i = 1'b0;
        step(1);

        cfg2_ch = 2'd3; cfg2_div = 8'd0; cfg2_en = 1'b1; cfg2_v = 1'b1;
        check_eq("oor_ready", ready2, 1);
        step(1);
        cfg2_v = 1'b0;

        cfg(2'd0, 8'd3, 1'b1);
        check_eq("unlocked_tick", tick_o, 0);

        pll_locked_i = 1'b1;
        step(42);
        check_eq("lock_e42", locked_o, 0);
        pll_locked_i = 1'b0;
        step(1);
        pll_locked_i = 1'b1;
        step(23);
        check_eq("lock_restart_e66", locked_o, 0);
        step(42);
        check_eq("lock_e108", locked_o, 0);
        step(1);
        check_eq("lock_e109", locked_o, 1);
        check_eq("lock_rise_tick", tick_o, 0);
        check_eq("oor_tick", tick2, 0);
        check_eq("oor_dclk", dclk2, 0);

        for (int k = 1; k <= 16; k++) begin
            step(1);
            check_eq("d3_tick", tick_o[0], (k % 4) == 0);
            check_eq("d3_dclk", div_clk_o[0], ((k / 4) % 2) == 1);
        end

        cfg(2'd1, 8'd5, 1'b1);
        step(8);
        cfg_ch_i = 2'd1; cfg_div_i = 8'd1; cfg_en_i = 1'b1; cfg_v_i = 1'b1;
        step(1);
        cfg_v_i = 1'b0;
        check_eq("swap_ready_a9", cfg_ready_o, 0);
        step(1);
        check_eq("swap_tick_a10", tick_o[1], 0);
        step(1);
        check_eq("swap_ready_a11", cfg_ready_o, 0);
        check_eq("swap_tick_a11", tick_o[1], 0);
        step(1);
        check_eq("swap_ready_a12", cfg_ready_o, 1);
        check_eq("swap_tick_a12", tick_o[1], 1);
        check_eq("swap_dclk_a12", div_clk_o[1], 0);
        step(1);
        check_eq("swap_tick_a13", tick_o[1], 0);
        step(1);
        check_eq("swap_tick_a14", tick_o[1], 1);
        check_eq("swap_dclk_a14", div_clk_o[1], 1);

        cfg(2'd2, 8'd5, 1'b1);
        step(3);
        sync_i = 1'b1;
        cfg_ch_i = 2'd0; cfg_div_i = 8'd2; cfg_en_i = 1'b1; cfg_v_i = 1'b1;
        step(1);
        sync_i = 1'b0;
        cfg_v_i = 1'b0;
        check_eq("sync_tick", tick_o, 0);
        check_eq("sync_dclk", div_clk_o, 0);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check_eq("sync_t0", tick_o[0], (k % 3) == 0);
            check_eq("sync_t2", tick_o[2], (k % 6) == 0);
        end

        step(1);
        cfg(2'd2, 8'd5, 1'b0);
        step(4);
        check_eq("dis_tick_s18", tick_o[2], 1);
        check_eq("dis_dclk_s18", div_clk_o[2], 0);
        step(1);
        check_eq("dis_tick_s19", tick_o[2], 0);
        step(6);
        check_eq("dis_tick_s25", tick_o[2], 0);
        check_eq("dis_dclk_s25", div_clk_o[2], 0);

        cfg(2'd3, 8'd0, 1'b1);
        check_eq("d0_tick_c0", tick_o[3], 0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check_eq("d0_tick", tick_o[3], 1);
            check_eq("d0_dclk", div_clk_o[3], k % 2);
        end

        cfg(2'd2, 8'd255, 1'b1);
        step(255);
        check_eq("d255_tick_255", tick_o[2], 0);
        step(1);
        check_eq("d255_tick_256", tick_o[2], 1);
        check_eq("d255_dclk_256", div_clk_o[2], 1);
        step(1);
        check_eq("d255_tick_257", tick_o[2], 0);

        pll_locked_i = 1'b0;
        step(2);
        check_eq("loss_locked_p2", locked_o, 1);
        step(1);
        check_eq("loss_locked_p3", locked_o, 0);
        check_eq("loss_tick_p3", tick_o, 0);
        check_eq("loss_dclk_p3", div_clk_o, 0);

        pll_locked_i = 1'b1;
        for (int i = 0; i < 200 && !locked_o; i++) step(1);
        check_eq("relock", locked_o, 1);
        step(2);
        check_eq("relock_d0_tick", tick_o[3], 1);

        cfg_ch_i = 2'd1; cfg_div_i = 8'd7; cfg_en_i = 1'b1; cfg_v_i = 1'b1;
        step(1);
        cfg_v_i = 1'b0;
        check_eq("pend_ready", cfg_ready_o, 0);
        #3;
        reset_i = 1'b1;
        #1;
        check_eq("arst_locked", locked_o, 0);
        check_eq("arst_tick", tick_o, 0);
        check_eq("arst_dclk", div_clk_o, 0);
        check_eq("arst_ready", cfg_ready_o, 1);
        step(2);
        reset_i = 1'b0;
        step(2);
        check_eq("post_rst_locked", locked_o, 0);
        check_eq("post_rst_tick", tick_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
